hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage-register load enables, bubble injection,
// data-memory wait handling, halt, and a saturating stall-cycle counter.
// Control outputs are combinational from the state register and the inputs,
// so every decision acts on the edge that ends the current cycle.
module hazard_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exmem_dREN,
    input  logic        exmem_dWEN,
    input  logic        idex_MemRead,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        branch_taken,
    input  logic        jump_id,
    input  logic        halt_wb,
    output logic        pc_WEN,
    output logic        ifid_WEN,
    output logic        idex_WEN,
    output logic        exmem_WEN,
    output logic        memwb_WEN,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        halted,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic mem_op;
    logic load_use;
    logic hold_all;

    assign mem_op   = exmem_dREN | exmem_dWEN;
    // $zero is never a real dependency, so a load into r0 never stalls.
    assign load_use = idex_MemRead && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    // Decide next state and all stage enables/flushes for this cycle.
    always_comb begin
        next_state  = state;
        hold_all    = 1'b0;
        halted      = 1'b0;
        pc_WEN      = 1'b1;
        ifid_WEN    = 1'b1;
        idex_WEN    = 1'b1;
        exmem_WEN   = 1'b1;
        memwb_WEN   = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        // Freeze conditions: halt, or an outstanding data access.
        case (state)
            RUN: begin
                if (halt_wb) begin
                    hold_all   = 1'b1;
                    next_state = HALT;
                end else if (mem_op && !dhit) begin
                    hold_all   = 1'b1;
                    next_state = DWAIT;
                end
            end
            DWAIT: begin
                if (halt_wb) begin
                    hold_all   = 1'b1;
                    next_state = HALT;
                end else if (!dhit) begin
                    hold_all   = 1'b1;
                end else begin
                    // Access completes now; the normal hazard rules below
                    // steer this same cycle.
                    next_state = RUN;
                end
            end
            HALT: begin
                hold_all = 1'b1;
                halted   = 1'b1;
            end
            default: begin
                hold_all   = 1'b1;
                next_state = RUN;
            end
        endcase

        if (hold_all) begin
            pc_WEN    = 1'b0;
            ifid_WEN  = 1'b0;
            idex_WEN  = 1'b0;
            exmem_WEN = 1'b0;
            memwb_WEN = 1'b0;
        end else if (branch_taken) begin
            // Redirect wins over everything younger, fetch miss included.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, bubble into EX; older stages drain.
            pc_WEN     = 1'b0;
            ifid_WEN   = 1'b0;
            idex_flush = 1'b1;
        end else if (jump_id) begin
            ifid_flush = 1'b1;
        end else if (!ihit) begin
            // Fetch not back: keep PC, feed a bubble into ID.
            pc_WEN     = 1'b0;
            ifid_flush = 1'b1;
        end

        // Reset dominates: clear every stage register.
        if (!nRST) begin
            next_state  = RUN;
            halted      = 1'b0;
            pc_WEN      = 1'b0;
            ifid_WEN    = 1'b0;
            idex_WEN    = 1'b0;
            exmem_WEN   = 1'b0;
            memwb_WEN   = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end
    end

    // State register and saturating stall counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= RUN;
            stall_count <= 32'd0;
        end else begin
            state <= next_state;
            if ((state != HALT) && !pc_WEN && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus a randomized run against a rule-level reference model.
module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, exmem_dREN, exmem_dWEN, idex_MemRead;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        branch_taken, jump_id, halt_wb;
    logic        pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN;
    logic        ifid_flush, idex_flush, exmem_flush, halted;
    logic [31:0] stall_count;

    hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .idex_MemRead(idex_MemRead), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .branch_taken(branch_taken), .jump_id(jump_id), .halt_wb(halt_wb),
        .pc_WEN(pc_WEN), .ifid_WEN(ifid_WEN), .idex_WEN(idex_WEN),
        .exmem_WEN(exmem_WEN), .memwb_WEN(memwb_WEN),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halted(halted), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          m_state = 0;        // 0 run, 1 waiting on data, 2 halted
    logic [31:0] m_cnt = 32'd0;
    bit          cnt_known = 1'b0;
    logic [8:0]  obs;                // {5 WEN, 3 flush, halted}
    logic [31:0] c0;
    int          halt_cycles = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected {pc,ifid,idex,exmem,memwb WEN, ifid,idex,exmem flush, halted}.
    function automatic logic [8:0] model_out();
        logic [4:0] wen;
        logic [2:0] fl;
        logic       h;
        logic       lu;
        lu  = idex_MemRead && (idex_rt != 0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
        wen = 5'b11111;
        fl  = 3'b000;
        h   = 1'b0;
        if (!nRST) begin
            wen = 5'b0; fl = 3'b111;
        end else if (m_state == 2) begin
            wen = 5'b0; h = 1'b1;
        end else if (halt_wb || (m_state == 1 && !dhit) ||
                     (m_state == 0 && (exmem_dREN || exmem_dWEN) && !dhit)) begin
            wen = 5'b0;
        end else if (branch_taken) begin
            fl = 3'b111;
        end else if (lu) begin
            wen[4:3] = 2'b00; fl = 3'b010;
        end else if (jump_id) begin
            fl = 3'b100;
        end else if (!ihit) begin
            wen[4] = 1'b0; fl = 3'b100;
        end
        return {wen, fl, h};
    endfunction

    // One cycle: inputs already driven at negedge; compare, then advance model.
    task automatic cyc();
        logic [8:0]  e;
        int          ns;
        logic [31:0] nc;
        #1;
        e   = model_out();
        obs = {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN,
               ifid_flush, idex_flush, exmem_flush, halted};
        chk("outputs_vs_model", {23'd0, obs}, {23'd0, e});
        if (cnt_known) chk("stall_count_vs_model", stall_count, m_cnt);
        if (!nRST) begin
            ns = 0; nc = 32'd0;
        end else begin
            nc = (m_state != 2 && !e[8] && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
            if (m_state == 2 || halt_wb) ns = 2;
            else if (m_state == 0 && (exmem_dREN || exmem_dWEN) && !dhit) ns = 1;
            else if (m_state == 1 && dhit) ns = 0;
            else ns = m_state;
        end
        @(posedge CLK);
        #1;
        if (!nRST) cnt_known = 1'b1;
        m_state = ns;
        m_cnt   = nc;
        @(negedge CLK);
    endtask

    task automatic idle();
        nRST = 1'b1; ihit = 1'b1; dhit = 1'b1;
        exmem_dREN = 1'b0; exmem_dWEN = 1'b0; idex_MemRead = 1'b0;
        idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        branch_taken = 1'b0; jump_id = 1'b0; halt_wb = 1'b0;
    endtask

    task automatic rand_in();
        ihit         = ($urandom_range(0, 3) != 0);
        dhit         = ($urandom_range(0, 2) != 0);
        exmem_dREN   = ($urandom_range(0, 3) == 0);
        exmem_dWEN   = ($urandom_range(0, 5) == 0);
        idex_MemRead = ($urandom_range(0, 2) == 0);
        idex_rt      = 5'($urandom_range(0, 3));
        ifid_rs      = 5'($urandom_range(0, 3));
        ifid_rt      = 5'($urandom_range(0, 3));
        branch_taken = ($urandom_range(0, 7) == 0);
        jump_id      = ($urandom_range(0, 5) == 0);
        halt_wb      = ($urandom_range(0, 79) == 0);
    endtask

    initial begin
        idle();
        nRST = 1'b0;
        @(negedge CLK);

        // Reset: everything frozen and flushed, counter cleared.
        cyc();
        chk("reset_outputs", {23'd0, obs}, {23'd0, 9'b00000_111_0});
        cyc();
        chk("reset_count", stall_count, 32'd0);

        idle();
        cyc();
        chk("run_idle", {23'd0, obs}, {23'd0, 9'b11111_000_0});
        chk("run_idle_count", stall_count, 32'd0);

        // Load-use on rs.
        c0 = stall_count;
        idex_MemRead = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        cyc();
        chk("load_use_out", {23'd0, obs}, {23'd0, 9'b00111_010_0});
        chk("load_use_count", stall_count, c0 + 32'd1);

        // Load into $zero is not a hazard.
        c0 = stall_count;
        idex_rt = 5'd0; ifid_rs = 5'd0;
        cyc();
        chk("zero_reg_out", {23'd0, obs}, {23'd0, 9'b11111_000_0});
        chk("zero_reg_count", stall_count, c0);

        // Data wait: one detect cycle in RUN plus three in DWAIT, then hit.
        idle();
        c0 = stall_count;
        exmem_dREN = 1'b1; dhit = 1'b0;
        repeat (4) begin
            cyc();
            chk("dwait_hold", {27'd0, obs[8:4]}, 32'd0);
        end
        dhit = 1'b1;
        cyc();
        chk("dwait_release", {23'd0, obs}, {23'd0, 9'b11111_000_0});
        chk("dwait_count", stall_count, c0 + 32'd4);
        idle();
        cyc();
        chk("dwait_back_run", {23'd0, obs}, {23'd0, 9'b11111_000_0});

        // Branch beats load-use and fetch miss.
        branch_taken = 1'b1; idex_MemRead = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ihit = 1'b0;
        cyc();
        chk("branch_prio", {23'd0, obs}, {23'd0, 9'b11111_111_0});

        // Halt while waiting on data.
        idle();
        exmem_dREN = 1'b1; dhit = 1'b0;
        cyc();
        cyc();
        halt_wb = 1'b1; dhit = 1'b1;
        cyc();
        chk("halt_in_dwait", {27'd0, obs[8:4]}, 32'd0);
        repeat (4) begin
            rand_in();
            cyc();
            chk("halted_frozen", {23'd0, obs}, {23'd0, 9'b00000_000_1});
        end
        idle();
        nRST = 1'b0;
        cyc();
        idle();
        cyc();
        chk("post_halt_count", stall_count, 32'd0);
        chk("post_halt_run", {23'd0, obs}, {23'd0, 9'b11111_000_0});

        // Saturation from a preloaded count.
        force dut.stall_count = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count;
        m_cnt = 32'hFFFF_FFFE;
        ihit = 1'b0;
        cyc();
        cyc();
        chk("saturate", stall_count, 32'hFFFF_FFFF);
        cyc();
        chk("saturate_hold", stall_count, 32'hFFFF_FFFF);
        idle();
        nRST = 1'b0;
        cyc();

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            if (m_state == 2) halt_cycles++;
            if (halt_cycles >= 4 || $urandom_range(0, 199) == 0) begin
                nRST = 1'b0;
                halt_cycles = 0;
            end else begin
                nRST = 1'b1;
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
